// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS datapath.
// Moore FSM that walks each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath enables for the current cycle.
// Memory states can be stretched by MEM_WAIT stall cycles using a small wait counter.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int MEM_WAIT = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                InstrDone,
    output logic                Illegal,
    output logic [3:0]          State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        BR       = 4'd8,
        JMP      = 4'd9,
        I_EX     = 4'd10,
        I_WB     = 4'd11,
        ILL      = 4'd12
    } state_t;

    // Opcode constants, zero-extended (or truncated) to the configured opcode width.
    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    // Final wait-counter value of a memory state; MEM_WAIT is only meaningful in 0..15.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t                state;
    state_t                nextState;
    logic   [3:0]          waitCnt;
    logic                  waitLast;
    logic   [OPCODE_W-1:0] opReg;
    logic                  isLoad;

    assign waitLast = (waitCnt == WAIT_LAST);
    assign isLoad   = (opReg == OP_LW);
    assign State    = state;

    // State register; reset aborts whatever instruction is in flight and restarts at FETCH.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Wait counter restarts on every state change and saturates at the final wait cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            waitCnt <= 4'd0;
        end else if (nextState != state) begin
            waitCnt <= 4'd0;
        end else if (!waitLast) begin
            waitCnt <= waitCnt + 4'd1;
        end
    end

    // Capture the opcode in DECODE so MEM_ADDR can pick load vs store after the IR input moves on.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            opReg <= '0;
        end else if (state == DECODE) begin
            opReg <= Opcode;
        end
    end

    // Next-state logic; memory states hold until the wait counter reaches its final value.
    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH: begin
                nextState = waitLast ? DECODE : FETCH;
            end
            DECODE: begin
                if (Opcode == OP_RTYPE) begin
                    nextState = R_EX;
                end else if ((Opcode == OP_LW) || (Opcode == OP_SW)) begin
                    nextState = MEM_ADDR;
                end else if (Opcode == OP_BEQ) begin
                    nextState = BR;
                end else if (Opcode == OP_ADDI) begin
                    nextState = I_EX;
                end else if (Opcode == OP_J) begin
                    nextState = JMP;
                end else begin
                    nextState = ILL;
                end
            end
            MEM_ADDR: begin
                nextState = isLoad ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                nextState = waitLast ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                nextState = FETCH;
            end
            MEM_WR: begin
                nextState = waitLast ? FETCH : MEM_WR;
            end
            R_EX: begin
                nextState = R_WB;
            end
            R_WB: begin
                nextState = FETCH;
            end
            BR: begin
                nextState = FETCH;
            end
            JMP: begin
                nextState = FETCH;
            end
            I_EX: begin
                nextState = I_WB;
            end
            I_WB: begin
                nextState = FETCH;
            end
            ILL: begin
                nextState = FETCH;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    // Moore output decode from the current state and wait counter; everything defaults low.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        InstrDone   = 1'b0;
        Illegal     = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
                IRWrite = waitLast;
                PCWrite = waitLast;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 2'b00;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                RegDst    = 1'b0;
                InstrDone = 1'b1;
            end
            MEM_WR: begin
                IorD      = 1'b1;
                MemWrite  = waitLast;
                InstrDone = waitLast;
            end
            R_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
            end
            JMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
            end
            I_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            I_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b0;
                InstrDone = 1'b1;
            end
            ILL: begin
                Illegal   = 1'b1;
                InstrDone = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: three instances with MEM_WAIT 0, 2 and 3,
// directed instruction sequences plus random opcode streams checked cycle by cycle
// against an instruction-level model of the expected control sequence.
module tb_multicycle_control;

    localparam int NDUT = 3;

    logic Clk = 1'b0;
    logic rst [NDUT];
    logic [5:0] op [NDUT];

    logic pcw [NDUT], pcwc [NDUT], iord [NDUT], mr [NDUT], mw [NDUT];
    logic irw [NDUT], m2r [NDUT], rdst [NDUT], rw [NDUT], asa [NDUT];
    logic [1:0] asb [NDUT], aop [NDUT], psrc [NDUT];
    logic done [NDUT], ill [NDUT];
    logic [3:0] st [NDUT];
    logic [21:0] obs [NDUT];

    int waitOf [NDUT] = '{0, 2, 3};
    int checks = 0;
    int fails = 0;

    typedef struct {
        int st;
        bit last;
    } step_t;

    // Free-running clock shared by all instances.
    always #5 Clk = ~Clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        multicycle_control #(
            .OPCODE_W(6),
            .MEM_WAIT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) dut (
            .Clk(Clk),
            .Reset(rst[g]),
            .Opcode(op[g]),
            .PCWrite(pcw[g]),
            .PCWriteCond(pcwc[g]),
            .IorD(iord[g]),
            .MemRead(mr[g]),
            .MemWrite(mw[g]),
            .IRWrite(irw[g]),
            .MemtoReg(m2r[g]),
            .RegDst(rdst[g]),
            .RegWrite(rw[g]),
            .ALUSrcA(asa[g]),
            .ALUSrcB(asb[g]),
            .ALUOp(aop[g]),
            .PCSource(psrc[g]),
            .InstrDone(done[g]),
            .Illegal(ill[g]),
            .State(st[g])
        );
        assign obs[g] = {st[g], pcw[g], pcwc[g], iord[g], mr[g], mw[g], irw[g], m2r[g],
                         rdst[g], rw[g], asa[g], asb[g], aop[g], psrc[g], done[g], ill[g]};
    end

    // Expected control word for one cycle, straight from the per-state output table.
    function automatic logic [21:0] expWord(input int s, input bit last);
        logic ePcw, ePcwc, eIord, eMr, eMw, eIrw, eM2r, eRdst, eRw, eAsa, eDone, eIll;
        logic [1:0] eAsb, eAop, ePsrc;
        {ePcw, ePcwc, eIord, eMr, eMw, eIrw, eM2r, eRdst, eRw, eAsa, eDone, eIll} = '0;
        eAsb = 2'b00;
        eAop = 2'b00;
        ePsrc = 2'b00;
        case (s)
            0:  begin eMr = 1; eAsb = 2'b01; eIrw = last; ePcw = last; end
            1:  begin eAsb = 2'b11; end
            2:  begin eAsa = 1; eAsb = 2'b10; end
            3:  begin eIord = 1; eMr = 1; end
            4:  begin eRw = 1; eM2r = 1; eDone = 1; end
            5:  begin eIord = 1; eMw = last; eDone = last; end
            6:  begin eAsa = 1; eAop = 2'b10; end
            7:  begin eRw = 1; eRdst = 1; eDone = 1; end
            8:  begin eAsa = 1; eAop = 2'b01; ePcwc = 1; ePsrc = 2'b01; eDone = 1; end
            9:  begin ePcw = 1; ePsrc = 2'b10; eDone = 1; end
            10: begin eAsa = 1; eAsb = 2'b10; end
            11: begin eRw = 1; eDone = 1; end
            12: begin eIll = 1; eDone = 1; end
            default: begin eIll = 0; end
        endcase
        return {4'(s), ePcw, ePcwc, eIord, eMr, eMw, eIrw, eM2r, eRdst, eRw, eAsa,
                eAsb, eAop, ePsrc, eDone, eIll};
    endfunction

    // Synchronous reset of one instance; returns just after the edge, inside the first FETCH cycle.
    task automatic applyReset(input int sel);
        rst[sel] = 1'b1;
        @(posedge Clk);
        #1;
        rst[sel] = 1'b0;
    endtask

    // Compare one sampled control word against its expected value.
    task automatic checkOutput(input string tag, input int cyc, input logic [21:0] got,
                               input logic [21:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Run one instruction (or its first maxCycles cycles) on an instance and check every cycle.
    task automatic applyStimulus(input int sel, input logic [5:0] opc, input int maxCycles);
        step_t q[$];
        int w;
        string tag;
        w = waitOf[sel];
        tag = $sformatf("dut%0d_op%b", sel, opc);
        for (int k = 0; k <= w; k++) q.push_back('{0, k == w});
        q.push_back('{1, 1'b1});
        case (opc)
            6'b000000: begin q.push_back('{6, 1'b1}); q.push_back('{7, 1'b1}); end
            6'b100011: begin
                q.push_back('{2, 1'b1});
                for (int k = 0; k <= w; k++) q.push_back('{3, k == w});
                q.push_back('{4, 1'b1});
            end
            6'b101011: begin
                q.push_back('{2, 1'b1});
                for (int k = 0; k <= w; k++) q.push_back('{5, k == w});
            end
            6'b000100: q.push_back('{8, 1'b1});
            6'b001000: begin q.push_back('{10, 1'b1}); q.push_back('{11, 1'b1}); end
            6'b000010: q.push_back('{9, 1'b1});
            default:   q.push_back('{12, 1'b1});
        endcase
        op[sel] = opc;
        for (int i = 0; i < q.size() && i < maxCycles; i++) begin
            @(negedge Clk);
            checkOutput(tag, i, obs[sel], expWord(q[i].st, q[i].last));
            if (q[i].st == 2) op[sel] = 6'($urandom);
        end
    endtask

    // Random opcode drawn from the legal set, with a share of unsupported values.
    function automatic logic [5:0] randOp();
        logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        int idx;
        logic [5:0] r;
        idx = int'($urandom_range(0, 7));
        if (idx < 6) return legal[idx];
        r = 6'($urandom);
        foreach (legal[k]) if (r == legal[k]) r = 6'b111111;
        return r;
    endfunction

    // Bound on total run time so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d fails=%0d", checks, fails);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequences first, then random instruction streams on every instance.
    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1;
            op[i] = 6'b000000;
        end
        repeat (2) @(posedge Clk);
        #1;

        applyReset(0);
        applyStimulus(0, 6'b000000, 99);
        applyStimulus(0, 6'b100011, 99);
        applyStimulus(0, 6'b000100, 99);
        applyStimulus(0, 6'b000010, 99);
        applyStimulus(0, 6'b111111, 99);
        applyStimulus(0, 6'b001000, 99);
        applyStimulus(0, 6'b101011, 99);
        for (int n = 0; n < 25; n++) applyStimulus(0, randOp(), 99);

        applyReset(1);
        applyStimulus(1, 6'b101011, 99);
        applyStimulus(1, 6'b100011, 99);
        for (int n = 0; n < 25; n++) applyStimulus(1, randOp(), 99);

        applyReset(2);
        applyStimulus(2, 6'b100011, 8);
        applyReset(2);
        applyStimulus(2, 6'b000000, 99);
        applyStimulus(2, 6'b111111, 99);
        for (int n = 0; n < 25; n++) applyStimulus(2, randOp(), 99);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
